// File: rtl/alu_cmd_driver.sv
// rtl/alu_cmd_driver.sv - command/response sequencer driving an 8-bit combinational ALU
// Accepts one command at a time, holds ALU inputs for SETTLE_CYCLES, then captures the result.
module alu_cmd_driver #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic       cmd_use_acc,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_zero,
    output logic [7:0] acc,
    output logic [7:0] ops_done,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [7:0] alu_out,
    input  logic       alu_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic [2:0] alu_sel_q, alu_sel_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_zero_q, rsp_zero_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] ops_done_q, ops_done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            alu_a_q    <= 8'd0;
            alu_b_q    <= 8'd0;
            alu_sel_q  <= 3'd0;
            rsp_data_q <= 8'd0;
            rsp_zero_q <= 1'b0;
            acc_q      <= 8'd0;
            ops_done_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sel_q  <= alu_sel_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
            acc_q      <= acc_d;
            ops_done_q <= ops_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        acc_d      = acc_q;
        ops_done_d = ops_done_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    alu_a_d   = cmd_use_acc ? acc_q : cmd_a;
                    alu_b_d   = cmd_b;
                    alu_sel_d = cmd_op;
                    cnt_d     = CNT_LOAD;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // ALU inputs have been stable for SETTLE_CYCLES once the counter drains
                if (cnt_q == 4'd0) begin
                    rsp_data_d = alu_out;
                    rsp_zero_d = alu_zero;
                    acc_d      = alu_out;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    ops_done_d = ops_done_q + 8'd1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign acc       = acc_q;
    assign ops_done  = ops_done_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb/tb_alu_cmd_driver.sv - self-checking bench for alu_cmd_driver with a behavioural ALU
module tb_alu_cmd_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic logic [7:0] alu_fn(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        case (s)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return {a[6:0], 1'b0};
            3'd6:    return {1'b0, a[7:1]};
            default: return a;
        endcase
    endfunction

    function automatic logic [7:0] ref_fn(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        int ia, ib, r;
        ia = int'(a);
        ib = int'(b);
        case (s)
            3'd0:    r = (ia + ib) % 256;
            3'd1:    r = (ia - ib + 256) % 256;
            3'd2:    r = ia & ib;
            3'd3:    r = ia | ib;
            3'd4:    r = ia ^ ib;
            3'd5:    r = (ia * 2) % 256;
            3'd6:    r = ia / 2;
            default: r = ia;
        endcase
        return 8'(r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Instance with the default settle window
    logic       rst1_n, cv1, cr1, ua1, rv1, rr1, rz1, az1;
    logic [2:0] op1, as1;
    logic [7:0] a1, b1, rd1, acc1, ops1, aa1, ab1, ao1;

    alu_cmd_driver #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .cmd_valid(cv1), .cmd_ready(cr1), .cmd_op(op1),
        .cmd_a(a1), .cmd_b(b1), .cmd_use_acc(ua1), .rsp_valid(rv1), .rsp_ready(rr1),
        .rsp_data(rd1), .rsp_zero(rz1), .acc(acc1), .ops_done(ops1),
        .alu_a(aa1), .alu_b(ab1), .alu_sel(as1), .alu_out(ao1), .alu_zero(az1)
    );
    assign ao1 = alu_fn(as1, aa1, ab1);
    assign az1 = (ao1 == 8'h00);

    // Instance with a three-cycle settle window
    logic       rst3_n, cv3, cr3, ua3, rv3, rr3, rz3, az3;
    logic [2:0] op3, as3;
    logic [7:0] a3, b3, rd3, acc3, ops3, aa3, ab3, ao3;

    alu_cmd_driver #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .cmd_valid(cv3), .cmd_ready(cr3), .cmd_op(op3),
        .cmd_a(a3), .cmd_b(b3), .cmd_use_acc(ua3), .rsp_valid(rv3), .rsp_ready(rr3),
        .rsp_data(rd3), .rsp_zero(rz3), .acc(acc3), .ops_done(ops3),
        .alu_a(aa3), .alu_b(ab3), .alu_sel(as3), .alu_out(ao3), .alu_zero(az3)
    );
    assign ao3 = alu_fn(as3, aa3, ab3);
    assign az3 = (ao3 == 8'h00);

    logic [7:0] m_acc;
    logic [7:0] m_ops;

    task automatic run_cmd1(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic ua, input string tag);
        logic [7:0] a_eff, exp_d;
        int lat;
        a_eff = ua ? m_acc : a;
        exp_d = ref_fn(op, a_eff, b);
        check({tag, " cmd_ready idle"}, cr1, 1);
        cv1 = 1'b1; op1 = op; a1 = a; b1 = b; ua1 = ua; rr1 = 1'b1;
        @(posedge clk); @(negedge clk);
        cv1 = 1'b0; op1 = 3'($urandom); a1 = 8'($urandom); b1 = 8'($urandom); ua1 = 1'($urandom);
        check({tag, " alu_a"}, aa1, a_eff);
        check({tag, " alu_b"}, ab1, b);
        check({tag, " alu_sel"}, as1, op);
        lat = 0;
        while (rv1 !== 1'b1 && lat < 40) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, 1);
        check({tag, " rsp_data"}, rd1, exp_d);
        check({tag, " rsp_zero"}, rz1, exp_d == 8'h00);
        check({tag, " acc"}, acc1, exp_d);
        @(posedge clk); @(negedge clk);
        m_acc = exp_d;
        m_ops = m_ops + 8'd1;
        check({tag, " ops_done"}, ops1, m_ops);
        check({tag, " rsp_valid low"}, rv1, 0);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       ua;
        logic [7:0] exp_d;
        logic       exp_z;
    } vec_t;

    vec_t vt[10];

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        vt[0] = '{3'd0, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0};
        vt[1] = '{3'd1, 8'h10, 8'h10, 1'b0, 8'h00, 1'b1};
        vt[2] = '{3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vt[3] = '{3'd5, 8'h81, 8'h00, 1'b0, 8'h02, 1'b0};
        vt[4] = '{3'd7, 8'h0F, 8'h00, 1'b0, 8'h0F, 1'b0};
        vt[5] = '{3'd4, 8'hAA, 8'hF0, 1'b1, 8'hFF, 1'b0};
        vt[6] = '{3'd2, 8'h3C, 8'h0F, 1'b0, 8'h0C, 1'b0};
        vt[7] = '{3'd3, 8'h50, 8'h0A, 1'b0, 8'h5A, 1'b0};
        vt[8] = '{3'd6, 8'h01, 8'h00, 1'b0, 8'h00, 1'b1};
        vt[9] = '{3'd1, 8'h55, 8'h01, 1'b1, 8'hFF, 1'b0};

        rst1_n = 1'b0; cv1 = 1'b0; op1 = 3'd0; a1 = 8'd0; b1 = 8'd0; ua1 = 1'b0; rr1 = 1'b0;
        rst3_n = 1'b0; cv3 = 1'b0; op3 = 3'd0; a3 = 8'd0; b3 = 8'd0; ua3 = 1'b0; rr3 = 1'b0;
        m_acc = 8'd0; m_ops = 8'd0;
        repeat (2) @(negedge clk);
        rst1_n = 1'b1; rst3_n = 1'b1;
        @(negedge clk);
        check("reset cmd_ready", cr1, 1);
        check("reset rsp_valid", rv1, 0);
        check("reset ops_done", ops1, 0);

        for (int i = 0; i < 10; i++) begin
            run_cmd1(vt[i].op, vt[i].a, vt[i].b, vt[i].ua, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table data", i), rd1, vt[i].exp_d);
            check($sformatf("vec%0d table zero", i), rz1, vt[i].exp_z);
        end

        // Backpressure with a second command waiting
        cv1 = 1'b1; op1 = 3'd0; a1 = 8'h20; b1 = 8'h22; ua1 = 1'b0; rr1 = 1'b0;
        @(posedge clk); @(negedge clk);
        op1 = 3'd2; a1 = 8'h77; b1 = 8'h0F;
        lat = 0;
        while (rv1 !== 1'b1 && lat < 40) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        check("bp latency", lat, 1);
        check("bp rsp_data", rd1, 8'h42);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            check("bp rsp_valid held", rv1, 1);
            check("bp rsp_data held", rd1, 8'h42);
            check("bp cmd_ready low", cr1, 0);
            check("bp alu_a held", aa1, 8'h20);
            check("bp ops_done held", ops1, m_ops);
        end
        rr1 = 1'b1;
        @(posedge clk); @(negedge clk);
        m_ops = m_ops + 8'd1;
        check("bp handshake ops_done", ops1, m_ops);
        check("bp handshake rsp_valid", rv1, 0);
        check("bp handshake cmd_ready", cr1, 1);
        check("bp not yet accepted", aa1, 8'h20);
        @(posedge clk); @(negedge clk);
        cv1 = 1'b0;
        check("bp second accepted", cr1, 0);
        check("bp second alu_a", aa1, 8'h77);
        check("bp second alu_sel", as1, 2);
        lat = 0;
        while (rv1 !== 1'b1 && lat < 40) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        check("bp second rsp_data", rd1, 8'h07);
        @(posedge clk); @(negedge clk);
        m_ops = m_ops + 8'd1;
        m_acc = 8'h07;
        check("bp second ops_done", ops1, m_ops);

        // Asynchronous reset between clock edges
        #1 rst1_n = 1'b0;
        #1;
        check("async cmd_ready", cr1, 1);
        check("async rsp_valid", rv1, 0);
        check("async rsp_data", rd1, 0);
        check("async rsp_zero", rz1, 0);
        check("async acc", acc1, 0);
        check("async ops_done", ops1, 0);
        check("async alu_a", aa1, 0);
        check("async alu_b", ab1, 0);
        check("async alu_sel", as1, 0);
        @(negedge clk);
        rst1_n = 1'b1;
        m_acc = 8'd0; m_ops = 8'd0;
        @(negedge clk);

        // Randomized commands, long enough for ops_done to wrap
        for (int i = 0; i < 260; i++) begin
            run_cmd1(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                     $sformatf("rnd%0d", i));
        end

        // Three-cycle settle window
        cv3 = 1'b1; op3 = 3'd0; a3 = 8'h12; b3 = 8'h34; ua3 = 1'b0; rr3 = 1'b1;
        @(posedge clk); @(negedge clk);
        cv3 = 1'b0; op3 = 3'd7; a3 = 8'hEE; b3 = 8'hEE;
        lat = 0;
        while (rv3 !== 1'b1 && lat < 40) begin
            check("s3 alu_a stable", aa3, 8'h12);
            check("s3 alu_b stable", ab3, 8'h34);
            check("s3 alu_sel stable", as3, 0);
            check("s3 cmd_ready low", cr3, 0);
            @(posedge clk); @(negedge clk);
            lat++;
        end
        check("s3 latency", lat, 3);
        check("s3 rsp_data", rd3, 8'h46);
        check("s3 rsp_zero", rz3, 0);
        @(posedge clk); @(negedge clk);
        check("s3 ops_done", ops3, 1);
        check("s3 acc", acc3, 8'h46);
        check("s3 cmd_ready back", cr3, 1);

        // Reset in the second EXEC cycle discards the command
        cv3 = 1'b1; op3 = 3'd1; a3 = 8'h09; b3 = 8'h04;
        @(posedge clk); @(negedge clk);
        cv3 = 1'b0;
        @(posedge clk); @(negedge clk);
        check("s3 mid exec no rsp", rv3, 0);
        #1 rst3_n = 1'b0;
        #1;
        check("s3 reset ops_done", ops3, 0);
        check("s3 reset acc", acc3, 0);
        check("s3 reset cmd_ready", cr3, 1);
        @(negedge clk);
        rst3_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); @(negedge clk);
            check("s3 no response after reset", rv3, 0);
        end
        check("s3 ops_done after reset", ops3, 0);
        check("s3 acc after reset", acc3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Sequential initiator for the 8-bit combinational ALU: it accepts operation commands over a valid/ready handshake, drives the ALU operand and select inputs, samples the ALU result and zero flag after a fixed settle window, and returns them over a valid/ready response channel. An internal 8-bit accumulator lets one command's result become the next command's A operand. The block sits between a sequencer or host and the ALU, and owns all timing on the ALU's input side.

## Interface

Parameters:
- SETTLE_CYCLES, 1: cycles the ALU inputs are held stable before sampling. Legal range is 1–15.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  3  ALU select code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL A, 110 SHR A, 111 PASS A.
- cmd_a  input  8  A operand.
- cmd_b  input  8  B operand.
- cmd_use_acc  input  1  when 1, the accumulator replaces cmd_a as the A operand.
- rsp_valid  output  1  result present.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  8  captured ALU result.
- rsp_zero  output  1  captured ALU zero flag.
- acc  output  8  accumulator value.
- ops_done  output  8  completed-response counter; wraps modulo 256.
- alu_a  output  8  to ALU A.
- alu_b  output  8  to ALU B.
- alu_sel  output  3  to ALU select.
- alu_out  input  8  from ALU result.
- alu_zero  input  1  from ALU zero flag.

## Operation

- The state machine has three states: IDLE, EXEC and RESP. Reset enters IDLE.
- **IDLE:** cmd_ready = 1. On a rising edge with cmd_valid && cmd_ready:
  - Register the operands: alu_a gets (cmd_use_acc ? acc : cmd_a), alu_b gets cmd_b, alu_sel gets cmd_op.
  - Load the settle counter with SETTLE_CYCLES-1.
  - Go to EXEC.
- **EXEC:** cmd_ready = 0. alu_a, alu_b and alu_sel are held constant. The counter decrements each cycle. On the edge where the counter is 0:
  - rsp_data gets alu_out, rsp_zero gets alu_zero and acc gets alu_out.
  - Go to RESP.
- **RESP:** rsp_valid = 1 and cmd_ready = 0. rsp_data and rsp_zero are stable. On an edge with rsp_ready = 1:
  - ops_done increments.
  - Go to IDLE.
- The accumulator is read when the command is accepted and written on capture. A chained command therefore sees the previous result.
- The ALU-side outputs keep their last driven values in IDLE and RESP. They change only on command acceptance.
- The block does no arithmetic of its own. All result and flag values come from the ALU. ops_done wraps 0xFF→0x00.
- cmd_* inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.
- **Reset (asynchronous, at any time, including mid-EXEC or mid-RESP):**
  - State returns to IDLE.
  - cmd_ready = 1.
  - rsp_valid = 0.
  - rsp_data, rsp_zero, acc, ops_done, alu_a, alu_b and alu_sel are all 0.
  - Any in-flight command is discarded and no response is produced.

## Timing

- Command accepted at edge N.
- The ALU inputs show the new operands in cycle N+1.
- The result is captured at edge N+SETTLE_CYCLES, and rsp_valid rises in the following cycle.
- With rsp_ready held at 1, the response handshake completes at edge N+SETTLE_CYCLES+1. cmd_ready is 1 again in the next cycle.
- Minimum command period is SETTLE_CYCLES+2 cycles (3 cycles at the default).
- cmd_ready and rsp_valid are registered (state-decoded). Neither depends combinationally on cmd_valid or rsp_ready.
- Under backpressure, rsp_valid stays high with unchanged data until rsp_ready is sampled high. There is no timeout.

## Test plan

The bench instantiates this block connected to the 8-bit ALU.

1. **Reset values.** Assert rst_n = 0 mid-cycle with no clock edge.
   - All outputs take their reset values immediately and cmd_ready = 1.
2. **Single command, default settle.** ADD, cmd_a = 0x05, cmd_b = 0x03, rsp_ready = 1.
   - rsp_data = 0x08, rsp_zero = 0, acc = 0x08.
   - rsp_valid rises 2 cycles after the accept edge; ops_done = 1.
3. **Zero-flag cases.** SUB 0x10−0x10, and separately ADD 0xFF+0x01.
   - Both give rsp_data = 0x00 and rsp_zero = 1.
   - Then SHL with A = 0x81 gives 0x02 and rsp_zero = 0.
4. **Accumulator chaining.** PASS A with 0x0F, then XOR with cmd_use_acc = 1, cmd_a = 0xAA (ignored), cmd_b = 0xF0.
   - alu_a = 0x0F during EXEC, rsp_data = 0xFF, acc = 0xFF.
5. **Backpressure.** Hold rsp_ready = 0 for 5 cycles in RESP while cmd_valid = 1 with new operands.
   - rsp_valid and rsp_data stay stable and cmd_ready = 0.
   - The new command is accepted only after the response handshake.
6. **SETTLE_CYCLES = 3 and reset mid-EXEC.**
   - Capture occurs 3 edges after accept, and the ALU inputs are stable throughout EXEC.
   - Asserting rst_n = 0 in the second EXEC cycle causes no response, ops_done stays 0 and acc = 0x00.
